// File: rtl/fpu_64_recip_seq.sv
// fpu_64_recip_seq: sequential Newton-Raphson double-precision reciprocal.
// One shared multiplier and one shared adder are time-multiplexed by an FSM.
// The operand mantissa is scaled into [0.5,1) and iterated as
// X <- X*(2 - D*X), starting from X0 = 48/17 - 32/17*D. The operand's
// exponent is folded back in when the result is assembled.
// Optional macro FPU_RECIP_SPECIAL_EN: decode zero/inf/NaN/denormal at accept
// and answer one edge later without iterating.

// Combinational double multiplier, round-to-nearest-even, denormals as zero.
module fpu_64_multiplier (
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] y,
  output logic        overflow,
  output logic        underflow
);
  logic         sign;
  logic [105:0] prod;
  logic [104:0] norm;
  logic [13:0]  exp;
  logic         up;
  logic [53:0]  mr;
  logic [51:0]  frac;

  // Multiply significands, normalise, round and range-check the exponent.
  always_comb begin
    sign      = a[63] ^ b[63];
    prod      = {53'b0, 1'b1, a[51:0]} * {53'b0, 1'b1, b[51:0]};
    norm      = prod[105] ? prod[104:0] : {prod[103:0], 1'b0};
    exp       = {3'b0, a[62:52]} + {3'b0, b[62:52]} - 14'd1023 + {13'b0, prod[105]};
    up        = norm[52] & ((|norm[51:0]) | norm[53]);
    mr        = {1'b0, 1'b1, norm[104:53]} + {53'b0, up};
    frac      = mr[53] ? mr[52:1] : mr[51:0];
    exp       = exp + {13'b0, mr[53]};
    y         = {sign, exp[10:0], frac};
    overflow  = 1'b0;
    underflow = 1'b0;
    if (a[62:52] == 11'd0 || b[62:52] == 11'd0) begin
      y = {sign, 63'b0};
    end else if ($signed(exp) >= 14'sd2047) begin
      overflow = 1'b1;
      y        = {sign, 11'h7FF, 52'b0};
    end else if ($signed(exp) <= 14'sd0) begin
      underflow = 1'b1;
      y         = {sign, 63'b0};
    end
  end
endmodule

// Combinational double adder, round-to-nearest-even, denormals as zero.
module fpu_64_adder (
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] y,
  output logic        overflow,
  output logic        underflow
);
  logic [63:0] big;
  logic [63:0] sml;
  logic [52:0] mbig;
  logic [52:0] msml;
  logic [10:0] d;
  logic [55:0] ext_s;
  logic [55:0] sh;
  logic [56:0] sum;
  logic [55:0] norm;
  logic [5:0]  lz;
  logic [13:0] exp;
  logic        up;
  logic [53:0] mr;
  logic [51:0] frac;

  function automatic logic [5:0] lzc56(input logic [55:0] v);
    logic [5:0] n;
    n = 6'd56;
    for (int i = 0; i < 56; i++) begin
      if (v[i]) n = 6'(55 - i);
    end
    return n;
  endfunction

  // Align the smaller magnitude with guard/round/sticky bits, add or
  // subtract, renormalise, round and range-check.
  always_comb begin
    if (b[62:0] > a[62:0]) begin
      big = b;
      sml = a;
    end else begin
      big = a;
      sml = b;
    end
    mbig  = (big[62:52] == 11'd0) ? 53'd0 : {1'b1, big[51:0]};
    msml  = (sml[62:52] == 11'd0) ? 53'd0 : {1'b1, sml[51:0]};
    d     = big[62:52] - sml[62:52];
    ext_s = {msml, 3'b0};
    if (d >= 11'd56) begin
      sh    = 56'd0;
      sh[0] = |msml;
    end else begin
      sh    = ext_s >> d;
      sh[0] = sh[0] | (|(ext_s & ((56'd1 << d) - 56'd1)));
    end
    if (big[63] ^ sml[63]) sum = {1'b0, mbig, 3'b0} - {1'b0, sh};
    else                   sum = {1'b0, mbig, 3'b0} + {1'b0, sh};
    exp = {3'b0, big[62:52]};
    lz  = lzc56(sum[55:0]);
    if (sum[56]) begin
      norm = {sum[56:2], sum[1] | sum[0]};
      exp  = exp + 14'd1;
    end else begin
      norm = sum[55:0] << lz;
      exp  = exp - {8'b0, lz};
    end
    up        = norm[2] & ((|norm[1:0]) | norm[3]);
    mr        = {1'b0, norm[55:3]} + {53'b0, up};
    frac      = mr[53] ? mr[52:1] : mr[51:0];
    exp       = exp + {13'b0, mr[53]};
    y         = {big[63], exp[10:0], frac};
    overflow  = 1'b0;
    underflow = 1'b0;
    if (big[62:52] == 11'd0 || sum == 57'd0) begin
      y = 64'd0;
    end else if ($signed(exp) >= 14'sd2047) begin
      overflow = 1'b1;
      y        = {big[63], 11'h7FF, 52'b0};
    end else if ($signed(exp) <= 14'sd0) begin
      underflow = 1'b1;
      y         = {big[63], 63'b0};
    end
  end
endmodule

module fpu_64_recip_seq #(
  parameter int WIDTH = 64,
  parameter int ITERS = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       flags
);
  localparam logic [63:0] C1  = 64'h4006969696969697;
  localparam logic [63:0] C2  = 64'h3FFE1E1E1E1E1E1E;
  localparam logic [63:0] TWO = 64'h4000000000000000;

  typedef enum logic [2:0] {
    IDLE, INIT_MUL, INIT_ADD, IT_MUL1, IT_ADD, IT_MUL2, DONE
  } state_t;

  state_t      state, next_state;
  logic [63:0] d_r, x_r, t_r;
  logic        sign_r;
  logic [10:0] exp_r;
  logic [3:0]  cnt;
  logic        accept;
  logic        last_iter;
  logic [63:0] mul_a, mul_b, mul_y, add_a, add_b, add_y;
  logic        mul_ov, mul_un, add_ov, add_un;

  fpu_64_multiplier u_mul (.a(mul_a), .b(mul_b), .y(mul_y), .overflow(mul_ov), .underflow(mul_un));
  fpu_64_adder      u_add (.a(add_a), .b(add_b), .y(add_y), .overflow(add_ov), .underflow(add_un));

  assign last_iter = (cnt == 4'(ITERS - 1));

`ifdef FPU_RECIP_SPECIAL_EN
  logic        is_special;
  logic [63:0] spec_result;
  logic [1:0]  spec_flags;

  // Classify the incoming operand and prepare its immediate answer.
  always_comb begin
    is_special  = 1'b1;
    spec_result = 64'd0;
    spec_flags  = 2'b00;
    if (in[62:52] == 11'd0 && in[51:0] == 52'd0) begin
      spec_result = {in[63], 11'h7FF, 52'b0};
      spec_flags  = 2'b01;
    end else if (in[62:52] == 11'h7FF && in[51:0] == 52'd0) begin
      spec_result = {in[63], 63'b0};
    end else if (in[62:52] == 11'h7FF) begin
      spec_result = 64'h7FF8000000000000;
    end else if (in[62:52] == 11'd0) begin
      spec_result = {in[63], 11'h7FF, 52'b0};
      spec_flags  = 2'b10;
    end else begin
      is_special = 1'b0;
    end
  end
`endif

  // Route operands to the shared units purely from the current state.
  always_comb begin
    mul_a = d_r;
    mul_b = x_r;
    add_a = TWO;
    add_b = {~t_r[63], t_r[62:0]};
    case (state)
      INIT_MUL: begin mul_a = C2; mul_b = d_r; end
      IT_MUL2:  begin mul_a = x_r; mul_b = t_r; end
      INIT_ADD: add_a = C1;
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state and handshake outputs; a result taken in DONE may overlap
  // with the next accept so back-to-back operands lose no cycle.
  always_comb begin
    next_state = state;
    out_valid  = (state == DONE);
    in_ready   = (state == IDLE) || (state == DONE && out_ready);
    accept     = in_valid && in_ready;
    case (state)
      IDLE, DONE: begin
        if (state == DONE && out_ready) next_state = IDLE;
        if (accept) begin
`ifdef FPU_RECIP_SPECIAL_EN
          next_state = is_special ? DONE : INIT_MUL;
`else
          next_state = INIT_MUL;
`endif
        end
      end
      INIT_MUL: next_state = INIT_ADD;
      INIT_ADD: next_state = IT_MUL1;
      IT_MUL1:  next_state = IT_ADD;
      IT_ADD:   next_state = IT_MUL2;
      IT_MUL2:  next_state = last_iter ? DONE : IT_MUL1;
      default:  next_state = IDLE;
    endcase
  end

  // Datapath: capture the active unit's output and accumulate its flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_r    <= 64'd0;
      x_r    <= 64'd0;
      t_r    <= 64'd0;
      sign_r <= 1'b0;
      exp_r  <= 11'd0;
      cnt    <= 4'd0;
      result <= '0;
      flags  <= 2'b00;
    end else if (accept) begin
      d_r    <= {1'b0, 11'd1022, in[51:0]};
      sign_r <= in[63];
      exp_r  <= in[62:52];
      cnt    <= 4'd0;
`ifdef FPU_RECIP_SPECIAL_EN
      if (is_special) result <= spec_result;
      flags <= is_special ? spec_flags : 2'b00;
`else
      flags <= 2'b00;
`endif
    end else begin
      case (state)
        INIT_MUL, IT_MUL1: begin
          t_r   <= mul_y;
          flags <= flags | {mul_ov, mul_un};
        end
        INIT_ADD: begin
          x_r   <= add_y;
          cnt   <= 4'd0;
          flags <= flags | {add_ov, add_un};
        end
        IT_ADD: begin
          t_r   <= add_y;
          flags <= flags | {add_ov, add_un};
        end
        IT_MUL2: begin
          x_r   <= mul_y;
          flags <= flags | {mul_ov, mul_un};
          if (last_iter) result <= {sign_r, mul_y[62:52] + 11'd1022 - exp_r, mul_y[51:0]};
          else           cnt    <= cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end
endmodule
